// File: rtl/step_profile_gen.sv
// Stepper motion-profile generator: per time tick, computes a position target on one shared
// shift-add multiplier and steps cur_pos toward it. Define STEP_PROFILE_GEN_ACCEL_EN for the a*t*t/2 term.
module step_profile_gen #(
  parameter int VEL_W    = 16,
  parameter int TIME_W   = 16,
  parameter int POS_W    = 32,
  parameter int TICK_DIV = 1000,
  parameter int PULSE_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [VEL_W-1:0]  velocity,
  input  logic signed [VEL_W-1:0]  accel,
  input  logic [TIME_W-1:0]        duration,
  output logic                     busy,
  output logic                     done,
  output logic                     step,
  output logic                     dir,
  output logic signed [POS_W-1:0]  cur_pos,
  output logic                     overrun
);

`ifdef STEP_PROFILE_GEN_ACCEL_EN
  localparam int MW = VEL_W + 2*TIME_W + 1;
`else
  localparam int MW = VEL_W + TIME_W + 1;
`endif
  localparam int SW  = MW + 1;
  localparam int TDW = $clog2(TICK_DIV);
  localparam int PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int BW  = $clog2(TIME_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    MUL       = 3'd2,
    STEP_HI   = 3'd3,
    STEP_LO   = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t                   state;
  logic                     start_d;
  logic                     pending;
  logic [TDW-1:0]           tick_cnt;
  logic [TIME_W-1:0]        t;
  logic [TIME_W-1:0]        t_mul;
  logic [TIME_W-1:0]        dur;
  logic [TIME_W-1:0]        mplier;
  logic signed [VEL_W-1:0]  vel;
  logic [MW-1:0]            mcand;
  logic [MW-1:0]            prod;
  logic [BW-1:0]            bit_cnt;
  logic [PCW-1:0]           pulse_cnt;
  logic signed [POS_W-1:0]  origin;
  logic signed [POS_W-1:0]  target;
`ifdef STEP_PROFILE_GEN_ACCEL_EN
  logic signed [VEL_W-1:0]  acc;
  logic [1:0]               phase;
  logic signed [SW-1:0]     pv;
`else
  logic                     accel_unused;
  assign accel_unused = ^accel;
`endif

  logic                     start_rise;
  logic                     tick_fire;
  logic                     mul_last;
  logic [MW-1:0]            add_res;
  logic signed [SW-1:0]     result;

  // Magnitude in one extra bit so the most-negative input stays exact.
  function automatic logic [MW-1:0] mag(input logic signed [VEL_W-1:0] x);
    logic [MW-1:0] e;
    e = MW'(x);
    return x[VEL_W-1] ? (~e + MW'(1)) : e;
  endfunction

  function automatic logic signed [SW-1:0] signed_of(input logic [MW-1:0] m, input logic neg);
    logic signed [SW-1:0] e;
    e = {1'b0, m};
    return neg ? -e : e;
  endfunction

  // Edge detect, tick qualification and the multiplier's add/finish datapath.
  always_comb begin
    start_rise = start & ~start_d;
    tick_fire  = (state != IDLE) && (tick_cnt == TDW'(TICK_DIV - 1)) && (t != dur);
    add_res    = prod + (mplier[0] ? mcand : {MW{1'b0}});
`ifdef STEP_PROFILE_GEN_ACCEL_EN
    mul_last   = (phase == 2'd2);
    result     = pv + (signed_of(add_res, acc[VEL_W-1]) >>> 1);
`else
    mul_last   = 1'b1;
    result     = signed_of(add_res, vel[VEL_W-1]);
`endif
  end

  // Move sequencer: tick timing, shared multiplier and step pulse generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      pending   <= 1'b0;
      tick_cnt  <= {TDW{1'b0}};
      t         <= {TIME_W{1'b0}};
      t_mul     <= {TIME_W{1'b0}};
      dur       <= {TIME_W{1'b0}};
      mplier    <= {TIME_W{1'b0}};
      vel       <= {VEL_W{1'b0}};
      mcand     <= {MW{1'b0}};
      prod      <= {MW{1'b0}};
      bit_cnt   <= {BW{1'b0}};
      pulse_cnt <= {PCW{1'b0}};
      origin    <= {POS_W{1'b0}};
      target    <= {POS_W{1'b0}};
`ifdef STEP_PROFILE_GEN_ACCEL_EN
      acc       <= {VEL_W{1'b0}};
      phase     <= 2'd0;
      pv        <= {SW{1'b0}};
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b0;
      cur_pos   <= {POS_W{1'b0}};
      overrun   <= 1'b0;
    end else begin
      start_d <= start;
      done    <= 1'b0;
      if (state != IDLE) begin
        tick_cnt <= (tick_cnt == TDW'(TICK_DIV - 1)) ? {TDW{1'b0}} : tick_cnt + TDW'(1);
        if (tick_fire) t <= t + TIME_W'(1);
        // A tick landing while WAIT_TICK consumes the pending one is queued, not lost.
        if (state == WAIT_TICK) begin
          if (pending && !tick_fire) pending <= 1'b0;
        end else if (tick_fire) begin
          if (pending) overrun <= 1'b1;
          else         pending <= 1'b1;
        end
      end
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        busy    <= 1'b0;
        step    <= 1'b0;
        pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_rise) begin
              vel      <= velocity;
`ifdef STEP_PROFILE_GEN_ACCEL_EN
              acc      <= accel;
`endif
              dur      <= duration;
              origin   <= cur_pos;
              t        <= {TIME_W{1'b0}};
              tick_cnt <= {TDW{1'b0}};
              pending  <= 1'b0;
              busy     <= 1'b1;
              state    <= (duration == {TIME_W{1'b0}}) ? DONE : WAIT_TICK;
            end
          end
          WAIT_TICK: begin
            if (tick_fire || pending) begin
              state   <= MUL;
              bit_cnt <= {BW{1'b0}};
`ifdef STEP_PROFILE_GEN_ACCEL_EN
              phase   <= 2'd0;
`endif
            end
          end
          MUL: begin
            if (bit_cnt == {BW{1'b0}}) begin
              prod    <= {MW{1'b0}};
              bit_cnt <= BW'(1);
`ifdef STEP_PROFILE_GEN_ACCEL_EN
              case (phase)
                2'd0:    begin mcand <= mag(vel); mplier <= t; t_mul <= t; end
                2'd1:    begin mcand <= mag(acc); mplier <= t_mul; end
                default: begin mcand <= prod;     mplier <= t_mul; end
              endcase
`else
              mcand   <= mag(vel);
              mplier  <= t;
              t_mul   <= t;
`endif
            end else begin
              prod   <= add_res;
              mcand  <= {mcand[MW-2:0], 1'b0};
              mplier <= {1'b0, mplier[TIME_W-1:1]};
              if (bit_cnt == BW'(TIME_W)) begin
                bit_cnt <= {BW{1'b0}};
                if (mul_last) begin
                  target    <= origin + POS_W'(result);
                  pulse_cnt <= PCW'(PULSE_W - 1);
                  state     <= STEP_LO;
                end else begin
`ifdef STEP_PROFILE_GEN_ACCEL_EN
                  if (phase == 2'd0) pv <= signed_of(add_res, vel[VEL_W-1]);
                  phase <= phase + 2'd1;
`endif
                end
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          STEP_HI: begin
            if (!step) begin
              step      <= 1'b1;
              cur_pos   <= dir ? cur_pos + POS_W'(1) : cur_pos - POS_W'(1);
              pulse_cnt <= {PCW{1'b0}};
            end else if (pulse_cnt == PCW'(PULSE_W - 1)) begin
              step      <= 1'b0;
              pulse_cnt <= {PCW{1'b0}};
              state     <= STEP_LO;
            end else begin
              pulse_cnt <= pulse_cnt + PCW'(1);
            end
          end
          STEP_LO: begin
            // dir is set here so it settles a full cycle before step rises.
            if (pulse_cnt == PCW'(PULSE_W - 1)) begin
              pulse_cnt <= {PCW{1'b0}};
              if (cur_pos != target) begin
                dir   <= (target > cur_pos);
                state <= STEP_HI;
              end else if (t_mul == dur) begin
                state <= DONE;
              end else begin
                state <= WAIT_TICK;
              end
            end else begin
              pulse_cnt <= pulse_cnt + PCW'(1);
            end
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_profile_gen.sv
// Directed self-checking bench for step_profile_gen; one instance at TICK_DIV=64, one at 16 for overrun.
module tb_step_profile_gen;
  localparam int VW = 8;
  localparam int TW = 8;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic rst, start, start_f, abort;
  logic signed [VW-1:0] velocity, accel;
  logic [TW-1:0] duration;
  logic busy, done, step, dir, overrun;
  logic signed [PW-1:0] cur_pos;
  logic busy_f, done_f, step_f, dir_f, overrun_f;
  logic signed [PW-1:0] cur_pos_f;
  int n_cmp = 0;
  int n_bad = 0;

  step_profile_gen #(.VEL_W(VW), .TIME_W(TW), .POS_W(PW), .TICK_DIV(64), .PULSE_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .velocity(velocity), .accel(accel),
    .duration(duration), .busy(busy), .done(done), .step(step), .dir(dir),
    .cur_pos(cur_pos), .overrun(overrun));

  step_profile_gen #(.VEL_W(VW), .TIME_W(TW), .POS_W(PW), .TICK_DIV(16), .PULSE_W(2)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .abort(abort), .velocity(velocity), .accel(accel),
    .duration(duration), .busy(busy_f), .done(done_f), .step(step_f), .dir(dir_f),
    .cur_pos(cur_pos_f), .overrun(overrun_f));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one move on dut with start held high throughout; returns pulse statistics.
  task automatic run_move(input int v, input int a, input int d, input int budget,
                          output int rises, output int ups, output int bad_w,
                          output int dones, output int t_done);
    int hi;
    logic prev;
    hi = 0; prev = 1'b0; rises = 0; ups = 0; bad_w = 0; dones = 0; t_done = -1;
    start = 1'b0;
    @(negedge clk);
    velocity = VW'(v); accel = VW'(a); duration = TW'(d); start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (step && !prev) begin
        rises++;
        if (dir) ups++;
      end
      if (step) hi++;
      else begin
        if (prev && hi != 2) bad_w++;
        hi = 0;
      end
      if (done) begin
        dones++;
        if (t_done < 0) t_done = c;
      end
      prev = step;
      if (t_done > 0 && c >= t_done + 4) break;
    end
    start = 1'b0;
    check("move_finished", t_done > 0, 1);
  endtask

  initial begin
    int r, u, w, dn, td;
    rst = 1'b1; start = 1'b0; start_f = 1'b0; abort = 1'b0;
    velocity = '0; accel = '0; duration = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_pos", cur_pos, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    run_move(3, 0, 4, 600, r, u, w, dn, td);
    check("t1_pulses", r, 12);
    check("t1_dir_up", u, 12);
    check("t1_width", w, 0);
    check("t1_done_cnt", dn, 1);
    check("t1_pos", cur_pos, 12);
    check("t1_busy", busy, 0);
    check("t1_overrun", overrun, 0);

    run_move(-2, 0, 3, 600, r, u, w, dn, td);
    check("t2_pulses", r, 6);
    check("t2_dir_up", u, 0);
    check("t2_done_cnt", dn, 1);
    check("t2_pos", cur_pos, 6);
    check("t2_overrun", overrun, 0);

    run_move(7, 0, 0, 20, r, u, w, dn, td);
    check("t3_done_lat", td, 2);
    check("t3_pulses", r, 0);
    check("t3_done_cnt", dn, 1);
    check("t3_pos", cur_pos, 6);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    velocity = 8'sd40; accel = '0; duration = 8'd3; start_f = 1'b1;
    for (int c = 0; c < 2000 && !overrun_f; c++) @(negedge clk);
    check("t4_overrun_set", overrun_f, 1);
    check("t4_busy", busy_f, 1);
    check("t4_slow_overrun", overrun, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_overrun", overrun_f, 0);
    check("t4_rst_pos", cur_pos_f, 0);
    check("t4_rst_busy", busy_f, 0);
    check("t4_rst_step", step_f, 0);
    start_f = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    begin
      int rises;
      int dcount;
      logic prev;
      rises = 0; dcount = 0; prev = 1'b0;
      velocity = 8'sd5; accel = '0; duration = 8'd10; start = 1'b1;
      for (int c = 0; c < 300 && rises < 3; c++) begin
        @(negedge clk);
        if (step && !prev) rises++;
        prev = step;
      end
      check("t5_third_rise", rises, 3);
      abort = 1'b1; start = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      check("t5_step_low", step, 0);
      check("t5_busy", busy, 0);
      check("t5_pos", cur_pos, 3);
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (done) dcount++;
      end
      check("t5_no_done", dcount, 0);
      check("t5_pos_hold", cur_pos, 3);
    end

    run_move(-128, 0, 1, 1000, r, u, w, dn, td);
    check("t5b_pulses", r, 128);
    check("t5b_dir_up", u, 0);
    check("t5b_done_cnt", dn, 1);
    check("t5b_pos", cur_pos, -125);

`ifdef STEP_PROFILE_GEN_ACCEL_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_move(0, 4, 3, 800, r, u, w, dn, td);
    check("t6_pulses", r, 18);
    check("t6_dir_up", u, 18);
    check("t6_pos", cur_pos, 18);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
